stream_decipher_ks: RTL and testbench
=====================================

// Module: stream_decipher_ks
// PURPOSE
//  Receive end of the keystream cipher link: takes ciphertext nibbles from stream_cipher_ks over a
//  valid/ready channel, regenerates the identical LFSR keystream from the shared key, XORs it out
//  and presents plaintext on a registered valid/ready output. Sits directly downstream of the cipher
//  link; the transmitter uses the same seed, taps and advance rules, so both ends stay in lockstep.
// PARAMETERS
//  DATA_W  4        width of ciphertext/plaintext/key/LFSR state
//  TAPS    4'b1100  LFSR feedback mask (x^4+x^3+1, period 15)
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  key        in   DATA_W  shared key, sampled on key_load
//  key_load   in   1       1-cycle pulse: capture key into seed register
//  in_valid   in   1       ciphertext beat valid
//  in_ready   out  1       decipher can accept beat
//  in_sof     in   1       beat is first of frame (reseed), qualified by in_valid
//  msg_c      in   DATA_W  ciphertext nibble
//  out_valid  out  1       plaintext beat valid
//  out_ready  in   1       downstream accepts beat
//  out_sof    out  1       plaintext beat is first of frame
//  msg        out  DATA_W  plaintext nibble
//  key_zero   out  1       sticky: a zero key was loaded and substituted
// BEHAVIOUR
//  - Reset: state=IDLE, seed=0, ks=0, out_valid=0, out_sof=0, msg=0, key_zero=0, in_ready=0.
//  - FSM: IDLE -> RUN on key_load; RUN has no exit except reset. In IDLE in_ready=0.
//  - key_load: seed <= (key==0) ? 1 : key; key==0 sets key_zero (cleared only by reset).
//    Load in RUN never alters ks; new seed applies from the next accepted sof beat.
//  - key_load and accepted sof beat in the same cycle: beat uses the OLD seed; new seed stored.
//  - in_ready = (state==RUN) && (!out_valid || out_ready). Accept = in_valid && in_ready.
//  - Keystream value k = in_sof ? seed : ks. On accept: msg <= msg_c ^ k, out_sof <= in_sof,
//    out_valid <= 1, ks <= nxt(k), nxt(s) = {s[DATA_W-2:0], ^(s & TAPS)}.
//  - Latency: accept in cycle N -> out_valid/msg in cycle N+1. Full throughput 1 beat/cycle.
//  - out_valid && !out_ready: msg/out_sof held stable, in_ready=0, ks frozen (no beat lost).
//  - out_valid drops to 0 when out_ready=1 and no new accept that cycle.
//  - Beat without sof before any sof since reset uses ks=0 -> keystream stuck at 0; upstream
//    must start every session with sof (not flagged).
//  - Reset mid-frame: all state cleared, pending output dropped; key_load required again.
// CONFIGURATION
//  STREAM_DEC_CNT_EN defined: extra port frame_cnt out 16 = beats accepted since last sof;
//    accepted sof beat sets it to 1, each further accept +1, saturates at 16'hFFFF, reset 0.
//  Not defined: port and counter absent; all other behaviour identical.
// TESTING
//  1 key=4'b1110 load, sof beat msg_c=4'b0110 -> next cycle msg=4'b1000, out_sof=1.
//  2 continue, beat msg_c=4'b0101 (ks=4'b1100) -> msg=4'b1001, out_sof=0; 15 beats wrap ks to seed.
//  3 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, msg held, resumes with no loss/dup.
//  4 key=0 load -> key_zero=1, sof beat msg_c=4'b0001 -> msg=4'b0000 (seed 4'b0001).
//  5 key_load 4'b0011 mid-frame -> rest of frame still old stream; next sof uses 4'b0011.
//  6 rst_n low mid-frame -> out_valid=0, in_ready=0 immediately; beats ignored until key_load.

Source files
------------

// File: rtl/stream_decipher_ks.sv
// rtl/stream_decipher_ks.sv - keystream decipher: regenerates the LFSR keystream and XORs it off ciphertext beats
// Optional frame beat counter port frame_cnt enabled by defining STREAM_DEC_CNT_EN.
module stream_decipher_ks #(
    parameter int                DATA_W = 4,
    parameter logic [DATA_W-1:0] TAPS   = 4'b1100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] key,
    input  logic              key_load,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] msg_c,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic [DATA_W-1:0] msg,
`ifdef STREAM_DEC_CNT_EN
    output logic [15:0]       frame_cnt,
`endif
    output logic              key_zero
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] seed;
    logic [DATA_W-1:0] ks;
    logic [DATA_W-1:0] k_cur;
    logic              accept;

    function automatic logic [DATA_W-1:0] lfsr_nxt(input logic [DATA_W-1:0] s);
        return {s[DATA_W-2:0], ^(s & TAPS)};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (key_load) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                in_ready = !out_valid || out_ready;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;
    // A frame start always restarts from the seed held before any same-cycle key_load.
    assign k_cur  = in_sof ? seed : ks;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seed     <= '0;
            key_zero <= 1'b0;
        end else if (key_load) begin
            if (key == '0) begin
                seed     <= {{(DATA_W-1){1'b0}}, 1'b1};
                key_zero <= 1'b1;
            end else begin
                seed     <= key;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ks        <= '0;
            msg       <= '0;
            out_sof   <= 1'b0;
            out_valid <= 1'b0;
        end else if (accept) begin
            ks        <= lfsr_nxt(k_cur);
            msg       <= msg_c ^ k_cur;
            out_sof   <= in_sof;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef STREAM_DEC_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (accept) begin
            if (in_sof) begin
                frame_cnt <= 16'd1;
            end else if (frame_cnt != 16'hFFFF) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stream_decipher_ks.sv
// tb/tb_stream_decipher_ks.sv - directed table-driven bench for stream_decipher_ks
module tb_stream_decipher_ks;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key;
    logic       key_load;
    logic       in_valid;
    logic       in_ready;
    logic       in_sof;
    logic [3:0] msg_c;
    logic       out_valid;
    logic       out_ready;
    logic       out_sof;
    logic [3:0] msg;
    logic       key_zero;
`ifdef STREAM_DEC_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic       sof;
        logic [3:0] msg_c;
        logic [3:0] exp_msg;
    } vec_t;

    vec_t vecs[17];

    stream_decipher_ks dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key       (key),
        .key_load  (key_load),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sof    (in_sof),
        .msg_c     (msg_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sof   (out_sof),
        .msg       (msg),
`ifdef STREAM_DEC_CNT_EN
        .frame_cnt (frame_cnt),
`endif
        .key_zero  (key_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [3:0] k);
        key      = k;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
    endtask

    task automatic beat(input logic sof, input logic [3:0] c);
        in_valid = 1'b1;
        in_sof   = sof;
        msg_c    = c;
        step();
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    initial begin
        // keystream from seed 1110 under x^4+x^3+1; msg_c=0 exposes it directly
        vecs[0]  = '{1'b1, 4'b0110, 4'b1000};
        vecs[1]  = '{1'b0, 4'b0101, 4'b1001};
        vecs[2]  = '{1'b0, 4'b0000, 4'b1000};
        vecs[3]  = '{1'b0, 4'b0000, 4'b0001};
        vecs[4]  = '{1'b0, 4'b0000, 4'b0010};
        vecs[5]  = '{1'b0, 4'b0000, 4'b0100};
        vecs[6]  = '{1'b0, 4'b0000, 4'b1001};
        vecs[7]  = '{1'b0, 4'b0000, 4'b0011};
        vecs[8]  = '{1'b0, 4'b0000, 4'b0110};
        vecs[9]  = '{1'b0, 4'b0000, 4'b1101};
        vecs[10] = '{1'b0, 4'b0000, 4'b1010};
        vecs[11] = '{1'b0, 4'b0000, 4'b0101};
        vecs[12] = '{1'b0, 4'b0000, 4'b1011};
        vecs[13] = '{1'b0, 4'b0000, 4'b0111};
        vecs[14] = '{1'b0, 4'b0000, 4'b1111};
        vecs[15] = '{1'b0, 4'b0000, 4'b1110};
        vecs[16] = '{1'b1, 4'b1111, 4'b0001};

        rst_n     = 1'b0;
        key       = 4'b0;
        key_load  = 1'b0;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        msg_c     = 4'b0;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_out_valid", 16'(out_valid), 16'h0);
        chk("rst_out_sof", 16'(out_sof), 16'h0);
        chk("rst_msg", 16'(msg), 16'h0);
        chk("rst_key_zero", 16'(key_zero), 16'h0);
        chk("rst_in_ready", 16'(in_ready), 16'h0);
        rst_n = 1'b1;

        beat(1'b1, 4'b0101);
        chk("idle_ignore_valid", 16'(out_valid), 16'h0);

        load_key(4'b1110);
        chk("run_in_ready", 16'(in_ready), 16'h1);
        chk("load_key_zero", 16'(key_zero), 16'h0);

        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1;
            in_sof   = vecs[i].sof;
            msg_c    = vecs[i].msg_c;
            chk($sformatf("vec%0d_in_ready", i), 16'(in_ready), 16'h1);
            step();
            chk($sformatf("vec%0d_msg", i), 16'(msg), 16'(vecs[i].exp_msg));
            chk($sformatf("vec%0d_sof", i), 16'(out_sof), 16'(vecs[i].sof));
            chk($sformatf("vec%0d_valid", i), 16'(out_valid), 16'h1);
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        step();
        chk("drop_out_valid", 16'(out_valid), 16'h0);

        // backpressure: beat 1 must wait, then arrive exactly once
        beat(1'b1, 4'b0000);
        chk("stall_first_msg", 16'(msg), 16'b1110);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        msg_c     = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stall%0d_in_ready", i), 16'(in_ready), 16'h0);
            step();
            chk($sformatf("stall%0d_msg", i), 16'(msg), 16'b1110);
            chk($sformatf("stall%0d_valid", i), 16'(out_valid), 16'h1);
            chk($sformatf("stall%0d_sof", i), 16'(out_sof), 16'h1);
        end
        out_ready = 1'b1;
        step();
        chk("resume_msg1", 16'(msg), 16'b1100);
        chk("resume_sof1", 16'(out_sof), 16'h0);
        step();
        chk("resume_msg2", 16'(msg), 16'b1000);
        in_valid = 1'b0;
        step();

        load_key(4'b0000);
        chk("zero_key_flag", 16'(key_zero), 16'h1);
        beat(1'b1, 4'b0001);
        chk("zero_key_msg", 16'(msg), 16'b0000);
        beat(1'b0, 4'b0000);
        chk("zero_key_next", 16'(msg), 16'b0010);

        load_key(4'b1110);
        chk("key_zero_sticky", 16'(key_zero), 16'h1);
        beat(1'b1, 4'b0000);
        chk("mid_first", 16'(msg), 16'b1110);
        key      = 4'b0011;
        key_load = 1'b1;
        beat(1'b0, 4'b0000);
        key_load = 1'b0;
        chk("mid_load_old_stream", 16'(msg), 16'b1100);
        beat(1'b0, 4'b0000);
        chk("mid_after_load", 16'(msg), 16'b1000);
        beat(1'b1, 4'b0000);
        chk("new_seed_sof", 16'(msg), 16'b0011);

        key      = 4'b0101;
        key_load = 1'b1;
        beat(1'b1, 4'b0000);
        key_load = 1'b0;
        chk("same_cycle_old_seed", 16'(msg), 16'b0011);
        beat(1'b1, 4'b0000);
        chk("same_cycle_new_seed", 16'(msg), 16'b0101);

        beat(1'b0, 4'b0000);
        chk("pre_reset_valid", 16'(out_valid), 16'h1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 16'(out_valid), 16'h0);
        chk("async_rst_ready", 16'(in_ready), 16'h0);
        step();
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_sof   = 1'b1;
        msg_c    = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("post_rst%0d_valid", i), 16'(out_valid), 16'h0);
            chk($sformatf("post_rst%0d_ready", i), 16'(in_ready), 16'h0);
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;

        load_key(4'b1110);
        chk("post_rst_key_zero", 16'(key_zero), 16'h0);
        beat(1'b0, 4'b1010);
        chk("no_sof_stuck_msg", 16'(msg), 16'b1010);
        beat(1'b0, 4'b0110);
        chk("no_sof_stuck_msg2", 16'(msg), 16'b0110);
        beat(1'b1, 4'b0110);
        chk("post_rst_sof_msg", 16'(msg), 16'b1000);
        chk("post_rst_sof_flag", 16'(out_sof), 16'h1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
